// File: rtl/data_memory.sv
// Word-organised data memory: one synchronous write port and one registered,
// read-first read port sharing a single word address.
module data_memory #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    output logic [31:0] readData,
    input  logic [31:0] writeData,
    input  logic        MemRead,
    input  logic        MemWrite
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Array is not touched by rst; the declaration initialiser gives the
    // all-zero power-up/configuration image.
    logic [31:0] mem_q [DEPTH] = '{default: '0};

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           readData_q;
    logic [31:0]           readData_d;
    logic                  unused_addr_hi;

    // Upper address bits are ignored so accesses wrap modulo the depth.
    assign word_idx       = address[ADDR_WIDTH-1:0];
    assign unused_addr_hi = ^address[31:ADDR_WIDTH];

    always_comb begin
        readData_d = readData_q;
        if (MemRead) begin
            readData_d = mem_q[word_idx];
        end
    end

    // Read sees the pre-write contents on a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            readData_q <= '0;
        end else begin
            readData_q <= readData_d;
            if (MemWrite) begin
                mem_q[word_idx] <= writeData;
            end
        end
    end

    assign readData = readData_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory: reset, read/write, read-first
// collision, hold, address wrap, reset-blocked writes and back-to-back access.
module tb_data_memory;

    logic        clk;
    logic        rst;
    logic [31:0] address;
    logic [31:0] readData;
    logic [31:0] writeData;
    logic        MemRead;
    logic        MemWrite;

    int checks;
    int failures;

    data_memory #(.ADDR_WIDTH(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .address   (address),
        .readData  (readData),
        .writeData (writeData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle before sampling or changing inputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        address = 32'd0; writeData = 32'd0;
        step();
        checks++;
        if (readData !== 32'h0) begin
            failures++;
            $display("FAIL reset_first_edge: got %h expected %h", readData, 32'h0);
        end
        repeat (9) step();
        checks++;
        if (readData !== 32'h0) begin
            failures++;
            $display("FAIL reset_hold: got %h expected %h", readData, 32'h0);
        end
        rst = 1'b0;
    endtask

    task automatic test_read_unwritten();
        MemRead = 1'b1; address = 32'd5;
        step();
        checks++;
        if (readData !== 32'h0) begin
            failures++;
            $display("FAIL read_unwritten: got %h expected %h", readData, 32'h0);
        end
        MemRead = 1'b0;
    endtask

    task automatic test_write_read();
        MemWrite = 1'b1; address = 32'd6; writeData = 32'd14;
        step();
        MemWrite = 1'b0; MemRead = 1'b1; writeData = 32'd0;
        step();
        checks++;
        if (readData !== 32'd14) begin
            failures++;
            $display("FAIL write_readback: got %0d expected %0d", readData, 14);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (readData !== 32'd14) begin
                failures++;
                $display("FAIL readback_freerun[%0d]: got %0d expected %0d", i, readData, 14);
            end
        end
    endtask

    task automatic test_collision();
        MemRead = 1'b1; MemWrite = 1'b1; address = 32'd6; writeData = 32'd20;
        step();
        checks++;
        if (readData !== 32'd14) begin
            failures++;
            $display("FAIL collision_read_first: got %0d expected %0d", readData, 14);
        end
        MemWrite = 1'b0;
        step();
        checks++;
        if (readData !== 32'd20) begin
            failures++;
            $display("FAIL collision_new_value: got %0d expected %0d", readData, 20);
        end
    endtask

    task automatic test_hold_wrap();
        MemRead = 1'b0; address = 32'd5;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (readData !== 32'd20) begin
                failures++;
                $display("FAIL hold[%0d]: got %0d expected %0d", i, readData, 20);
            end
        end
        MemRead = 1'b1; address = 32'd1030;
        step();
        checks++;
        if (readData !== 32'd20) begin
            failures++;
            $display("FAIL wrap_read_1030: got %0d expected %0d", readData, 20);
        end
        // Store through a wrapped address with high bits set, read back at the low index.
        MemRead = 1'b0; MemWrite = 1'b1; address = 32'hFFFF_FC09; writeData = 32'hDEAD_BEEF;
        step();
        MemWrite = 1'b0; MemRead = 1'b1; address = 32'd9;
        step();
        checks++;
        if (readData !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL wrap_write_high_bits: got %h expected %h", readData, 32'hDEAD_BEEF);
        end
        MemRead = 1'b0;
    endtask

    task automatic test_reset_blocks_write();
        rst = 1'b1; MemWrite = 1'b1; MemRead = 1'b1; address = 32'd7; writeData = 32'd99;
        step();
        checks++;
        if (readData !== 32'h0) begin
            failures++;
            $display("FAIL reset_clears_readdata: got %h expected %h", readData, 32'h0);
        end
        rst = 1'b0; MemWrite = 1'b0; MemRead = 1'b1; address = 32'd7;
        step();
        checks++;
        if (readData !== 32'h0) begin
            failures++;
            $display("FAIL reset_blocked_write: got %0d expected %0d", readData, 0);
        end
        address = 32'd6;
        step();
        checks++;
        if (readData !== 32'd20) begin
            failures++;
            $display("FAIL contents_retained: got %0d expected %0d", readData, 20);
        end
        MemRead = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        vals[0] = 32'h0000_00A0; vals[1] = 32'h1234_5678;
        vals[2] = 32'hFFFF_FFFF; vals[3] = 32'h8000_0001;
        MemWrite = 1'b1;
        for (int i = 0; i < 4; i++) begin
            address = 32'd10 + 32'(i); writeData = vals[i];
            step();
        end
        MemWrite = 1'b0; MemRead = 1'b1;
        for (int i = 0; i < 4; i++) begin
            address = 32'd10 + 32'(i);
            step();
            checks++;
            if (readData !== vals[i]) begin
                failures++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, readData, vals[i]);
            end
        end
        MemRead = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        address = 32'd0; writeData = 32'd0;
        #2;
        test_reset();
        test_read_unwritten();
        test_write_read();
        test_collision();
        test_hold_wrap();
        test_reset_blocks_write();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
